// File: rtl/hazard_stall_if.sv
// hazard_stall_if: request/control bundle between the hazard sources
// (hazard detection, ID branch resolution, data memory, MEM/WB) and the
// stall/flush controller. The master side raises requests; the slave side
// (hazard_stall_ctrl) returns the pipeline enables, flushes and status.
interface hazard_stall_if #(
    parameter int CNT_W = 16
);
    // Requests into the controller
    logic             stall_en;
    logic             branch_taken;
    logic             hlt_dec;
    logic             dmem_busy;
    logic             mem_wb_hlt;

    // Pipeline controls and status out of the controller
    logic             pc_write_en;
    logic             if_id_write_en;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pipe_hold;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output stall_en, branch_taken, hlt_dec, dmem_busy, mem_wb_hlt,
        input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
               pipe_hold, halted, mem_timeout, stall_cycles
    );

    modport slave (
        input  stall_en, branch_taken, hlt_dec, dmem_busy, mem_wb_hlt,
        output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
               pipe_hold, halted, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush sequencer.
// Freezes or flushes the front end for load-use hazards, taken branches and
// HLT, holds the back end while data memory is busy, drains the pipe after
// HLT and parks in HALTED until reset. A wait counter flags a sticky
// mem_timeout after MAX_WAIT consecutive busy cycles.
// Optional feature macro: STALL_PERF_CNT_EN -- when defined, stall_cycles is
// a saturating count of frozen-front-end cycles; otherwise it reads zero.
module hazard_stall_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    hazard_stall_if.slave  bus
);
    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;
    localparam logic [1:0] S_HALTED   = 2'd3;

    // MAX_WAIT is limited to 2..255, so 8 bits always hold the wait count
    localparam int         WAIT_W     = 8;
    localparam logic [WAIT_W-1:0] MAX_WAIT_C  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] LAST_WAIT_C = WAIT_W'(MAX_WAIT - 1);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              ret_drain_q;
    logic              ret_drain_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              mem_timeout_q;

    logic [1:0]        eff_state;
    logic              pc_we;
    logic              if_id_we;
    logic              if_id_fl;
    logic              id_ex_bub;
    logic              hold;

    // Output decode and next-state selection; a MEM_WAIT whose memory just
    // went ready behaves exactly like the state it returns to, including that
    // state's own transitions, so an HLT or drain completion seen on the
    // release cycle is not lost.
    always_comb begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        if_id_fl    = 1'b0;
        id_ex_bub   = 1'b0;
        hold        = 1'b0;
        ret_drain_d = ret_drain_q;

        eff_state = state_q;
        if ((state_q == S_MEM_WAIT) && !bus.dmem_busy) begin
            eff_state = ret_drain_q ? S_DRAIN : S_RUN;
        end
        state_d = eff_state;

        case (eff_state)
            S_RUN: begin
                if (bus.dmem_busy) begin
                    hold        = 1'b1;
                    state_d     = S_MEM_WAIT;
                    ret_drain_d = 1'b0;
                end else if (bus.stall_en) begin
                    // branch_taken is re-evaluated once the bubble is inserted
                    id_ex_bub = 1'b1;
                end else if (bus.hlt_dec) begin
                    if_id_fl = 1'b1;
                    state_d  = S_DRAIN;
                end else if (bus.branch_taken) begin
                    pc_we    = 1'b1;
                    if_id_fl = 1'b1;
                end else begin
                    pc_we    = 1'b1;
                    if_id_we = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                // only reached with dmem_busy=1
                hold = 1'b1;
            end
            S_DRAIN: begin
                if_id_fl = 1'b1;
                if (bus.dmem_busy) begin
                    hold        = 1'b1;
                    state_d     = S_MEM_WAIT;
                    ret_drain_d = 1'b1;
                end else if (bus.mem_wb_hlt) begin
                    state_d = S_HALTED;
                end
            end
            default: begin
                hold = 1'b1;
            end
        endcase

        // While reset is held the front end is flushed and bubbled
        if (!rst_n) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            if_id_fl  = 1'b1;
            id_ex_bub = 1'b1;
            hold      = 1'b0;
        end
    end

    // Controller state and drain-return flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            ret_drain_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_drain_q <= ret_drain_d;
        end
    end

    // Consecutive-busy counter and sticky timeout; frozen once halted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else if (state_q != S_HALTED) begin
            if (bus.dmem_busy) begin
                if (wait_cnt_q < MAX_WAIT_C) begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                end
                if (wait_cnt_q == LAST_WAIT_C) begin
                    mem_timeout_q <= 1'b1;
                end
            end else begin
                wait_cnt_q <= '0;
            end
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q;

    // Saturating count of frozen-PC cycles spent in RUN or MEM_WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else if (((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && !pc_we
                     && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_q <= stall_cycles_q + 1'b1;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
`else
    logic [CNT_W-1:0] stall_cycles_zero;
    assign stall_cycles_zero = '0;
    assign bus.stall_cycles  = stall_cycles_zero;
`endif

    assign bus.pc_write_en    = pc_we;
    assign bus.if_id_write_en = if_id_we;
    assign bus.if_id_flush    = if_id_fl;
    assign bus.id_ex_bubble   = id_ex_bub;
    assign bus.pipe_hold      = hold;
    assign bus.halted         = (state_q == S_HALTED);
    assign bus.mem_timeout    = mem_timeout_q;
endmodule
